// File: rtl/aes_pkg.sv
// Shared AES key-schedule types: round-key bundle, round count, FSM states.
// Imported by key_expansion and key_schedule_ctrl.
package aes_pkg;

    localparam int AES_REG_SIZE   = 32;
    localparam int AES_VEC_SIZE   = 4;
    localparam int AES_NUM_ROUNDS = 10;

    typedef logic [AES_VEC_SIZE-1:0][AES_REG_SIZE-1:0] round_key_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        FINISH
    } ks_state_e;

endpackage

// File: rtl/key_expansion.sv
// Combinational AES-128 key-expansion round step (RotWord/SubWord/Rcon).
// Ports: key_in current round key, round operand (index in low bits of
// word 0, replicated), key_out next round key. Word 0 is the first AES word.
module key_expansion
    import aes_pkg::*;
#(
    parameter int regSize = 32,
    parameter int vecSize = 4
) (
    input  logic [vecSize-1:0][regSize-1:0] key_in,
    input  logic [vecSize-1:0][regSize-1:0] round,
    output logic [vecSize-1:0][regSize-1:0] key_out
);

    localparam int NB = regSize / 8;

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box = affine(x^254); x^254 is the GF(2^8) inverse, with 0 -> 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        logic [7:0] b;
        sq  = gmul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        b = acc;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [regSize-1:0] rot;
    logic [regSize-1:0] sub;
    logic [7:0]         rc;
    logic               round_unused;

    // Only the index nibble of word 0 matters; the other replicas are ignored.
    assign round_unused = ^round;

    always_comb begin
        rot = {key_in[vecSize-1][regSize-9:0],
               key_in[vecSize-1][regSize-1 -: 8]};
        sub = '0;
        for (int b = 0; b < NB; b++) begin
            sub[b*8 +: 8] = sbox(rot[b*8 +: 8]);
        end
        rc = rcon(round[0][3:0]);
        key_out = '0;
        key_out[0] = key_in[0] ^ sub ^ {rc, {(regSize-8){1'b0}}};
        for (int w = 1; w < vecSize; w++) begin
            key_out[w] = key_in[w] ^ key_out[w-1];
        end
    end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequencer that runs key_expansion NUM_ROUNDS times into an 11-entry
// round-key buffer with a registered read port.
// Ports: clk, rst (sync, active-high), start, key_in, busy, done,
// keys_valid, rd_idx, rd_key. Optional macro KEYSCHED_CACHE_EN skips
// re-expansion when the last completed key is requested again.
module key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int regSize    = 32,
    parameter int vecSize    = 4,
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [vecSize-1:0][regSize-1:0] key_in,
    output logic                            busy,
    output logic                            done,
    output logic                            keys_valid,
    input  logic [3:0]                      rd_idx,
    output logic [vecSize-1:0][regSize-1:0] rd_key
);

    typedef logic [vecSize-1:0][regSize-1:0] key_t;

    localparam logic [3:0] LAST_R  = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] MAX_IDX = 4'(NUM_ROUNDS);

    ks_state_e  state;
    ks_state_e  state_n;
    logic [3:0] r;
    key_t       cur;
    key_t       next_key;
    key_t       rnd_op;
    key_t       key_buf [0:NUM_ROUNDS];
    logic       hit;

`ifdef KEYSCHED_CACHE_EN
    key_t cache_key;
    logic cached;
    assign hit = cached && keys_valid && (key_in == cache_key);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        for (int w = 0; w < vecSize; w++) begin
            rnd_op[w] = {{(regSize-4){1'b0}}, r};
        end
    end

    key_expansion #(
        .regSize (regSize),
        .vecSize (vecSize)
    ) u_step (
        .key_in  (cur),
        .round   (rnd_op),
        .key_out (next_key)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = hit ? FINISH : EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (r == LAST_R) state_n = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r          <= 4'd0;
            keys_valid <= 1'b0;
            rd_key     <= '0;
`ifdef KEYSCHED_CACHE_EN
            cached     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && !hit) begin
                        key_buf[0] <= key_in;
                        cur        <= key_in;
                        r          <= 4'd0;
                        keys_valid <= 1'b0;
`ifdef KEYSCHED_CACHE_EN
                        cached     <= 1'b0;
`endif
                    end
                end
                EXPAND: begin
                    key_buf[r + 4'd1] <= next_key;
                    cur               <= next_key;
                    r                 <= r + 4'd1;
                end
                FINISH: begin
                    keys_valid <= 1'b1;
`ifdef KEYSCHED_CACHE_EN
                    cache_key  <= key_buf[0];
                    cached     <= 1'b1;
`endif
                end
                default: ;
            endcase
            rd_key <= (rd_idx <= MAX_IDX) ? key_buf[rd_idx] : '0;
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Scoreboard bench for key_schedule_ctrl against a word-level AES-128
// key-schedule model; done timing and read data are checked by a monitor.
module tb_key_schedule_ctrl;

    typedef logic [3:0][31:0] key_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    key_t       key_in = '0;
    logic       busy;
    logic       done;
    logic       keys_valid;
    logic [3:0] rd_idx = 4'd0;
    key_t       rd_key;

    key_schedule_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_q[$];
    key_t rd_q[$];
    logic rd_vld = 1'b0;
    logic rd_vld_q = 1'b0;

    logic [7:0] sb [0:255];
    key_t       m_sched [0:10];
    key_t       m_key;
    logic       m_valid = 1'b0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_vld_q <= rd_vld;
    end

    always @(negedge clk) begin
        if (done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 128'(cyc), 128'(0));
            end else begin
                chk("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
            end
        end
        if (rd_vld_q) begin
            if (rd_q.size() == 0) chk("rd_underflow", 128'(1), 128'(0));
            else chk("rd_key", rd_key, rd_q.pop_front());
        end
    end

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3)
                      ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic build_sched(input key_t k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[i];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++)
            for (int c = 0; c < 4; c++) m_sched[j][c] = w[4*j + c];
    endtask

    function automatic key_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d);
        key_t k;
        k[0] = a; k[1] = b; k[2] = c; k[3] = d;
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input key_t k);
        logic hit;
`ifdef KEYSCHED_CACHE_EN
        hit = m_valid && (k == m_key);
`else
        hit = 1'b0;
`endif
        key_in = k;
        start  = 1'b1;
        done_q.push_back(cyc + (hit ? 1 : 11));
        if (!hit) begin
            m_valid = 1'b0;
            m_key   = k;
            build_sched(k);
        end
        tick();
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(!hit));
        chk("kv_after_start", 128'(keys_valid), 128'(hit));
    endtask

    task automatic wait_done(input logic kv_stays);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (kv_stays) chk("kv_stays_high", 128'(keys_valid), 128'(1));
            if (done) got = 1'b1;
        end
        if (!got) begin
            chk("done_timeout", 128'(0), 128'(1));
            if (done_q.size() > 0) void'(done_q.pop_front());
        end
        tick();
        chk("kv_after_done", 128'(keys_valid), 128'(1));
        chk("busy_after_done", 128'(busy), 128'(0));
        m_valid = 1'b1;
    endtask

    task automatic do_read(input int idx, input key_t exp);
        rd_idx = 4'(idx);
        rd_vld = 1'b1;
        rd_q.push_back(exp);
        tick();
        rd_vld = 1'b0;
    endtask

    task automatic read_model(input int idx);
        do_read(idx, (idx > 10) ? key_t'(0) : m_sched[idx]);
    endtask

    key_t fips;
    key_t rk;

    initial begin
        build_sbox();
        fips = mk(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_kv", 128'(keys_valid), 128'(0));
        chk("rst_rd_key", rd_key, 128'(0));
        tick();

        do_start('0);
        wait_done(1'b0);
        do_read(1, mk(32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363));
        do_read(2, mk(32'h9b9898c9, 32'hf9fbfbaa, 32'h9b9898c9, 32'hf9fbfbaa));
        do_read(10, mk(32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e));

        do_start(fips);
        wait_done(1'b0);
        do_read(0, fips);
        do_read(1, mk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));
        do_read(10, mk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));
        for (int i = 11; i < 16; i++) read_model(i);

        rk = mk($urandom, $urandom, $urandom, $urandom);
        do_start(rk);
        tick();
        start = 1'b1;
        key_in = mk($urandom, $urandom, $urandom, $urandom);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0);
        for (int i = 0; i < 11; i++) read_model(i);

        do_start(mk($urandom, $urandom, $urandom, $urandom));
        repeat (4) tick();
        rst = 1'b1;
        if (done_q.size() > 0) void'(done_q.pop_back());
        tick();
        rst = 1'b0;
        m_valid = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_kv", 128'(keys_valid), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_rd_key", rd_key, 128'(0));
        tick();

        start = 1'b1;
        rst = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        chk("rst_wins_busy", 128'(busy), 128'(0));
        tick();
        chk("rst_wins_busy2", 128'(busy), 128'(0));

        do_start(fips);
        wait_done(1'b0);
        for (int i = 0; i < 11; i++) read_model(i);

`ifdef KEYSCHED_CACHE_EN
        do_start(fips);
        wait_done(1'b1);
`else
        do_start(fips);
        wait_done(1'b0);
`endif
        read_model(10);
        do_start(fips ^ key_t'(1));
        wait_done(1'b0);
        read_model(10);

        for (int n = 0; n < 4; n++) begin
            do_start(mk($urandom, $urandom, $urandom, $urandom));
            wait_done(1'b0);
            for (int j = 0; j < 6; j++) read_model(int'($urandom_range(0, 15)));
        end

        repeat (3) tick();
        chk("done_q_empty", 128'(done_q.size()), 128'(0));
        chk("rd_q_empty", 128'(rd_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles expected fewer", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Sequencer that drives the team's combinational key_expansion round step to produce the full AES-128 key schedule. It produces round keys 0..10 and stores them in an internal 11-entry round-key buffer. The SIMD cipher datapath reads round keys from this buffer by index. The block sits between the key-load path of the vector register file and the AES round datapath.

Parameters:
regSize, 32, width of one key word in bits
vecSize, 4, words per round key (AES-128)
NUM_ROUNDS, 10, number of expansion rounds; buffer depth is NUM_ROUNDS+1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a new expansion; sampled only in IDLE
key_in  input  [vecSize-1:0][regSize-1:0]  cipher key; word 0 is the first AES word
busy  output  1  high while expansion is in progress
done  output  1  one-cycle pulse when round key NUM_ROUNDS has been written
keys_valid  output  1  high while the buffer holds a complete schedule
rd_idx  input  4  round-key index to read, 0..NUM_ROUNDS
rd_key  output  [vecSize-1:0][regSize-1:0]  registered read data

Behaviour:
- Reset (rst=1 at a rising edge of clk): state<=IDLE; busy=0, done=0, keys_valid=0, rd_key=0, round counter r=0. Buffer contents need not be cleared.
- Reset mid-expansion: abort, go to IDLE, keys_valid=0. A new start is required.
- FSM states: IDLE, EXPAND, FINISH.
- IDLE, start=1 at edge N:
  - buf[0]<=key_in, cur<=key_in, r<=0, keys_valid<=0, state<=EXPAND.
  - busy is high from cycle N+1.
- EXPAND, each edge:
  - buf[r+1]<=next_key, cur<=next_key, r<=r+1.
  - The key_expansion round operand is r replicated into all vecSize words. Index 0 selects rcon 0x01, index 9 selects rcon 0x36.
  - After the write with r==NUM_ROUNDS-1, state<=FINISH.
- FINISH, one cycle: done=1, busy=0. At the edge, keys_valid<=1 and state<=IDLE.
- Latency: start sampled at edge N; 10 EXPAND edges at N+1..N+10. done is high during the cycle after edge N+10, i.e. 11 cycles after start. keys_valid is high from edge N+11.
- busy is high exactly in EXPAND. done is high exactly in FINISH.
- start while busy or in FINISH is ignored; it is not queued.
- start and rst together: rst wins.
- start in IDLE while keys_valid=1: keys_valid drops at the next edge and the schedule is re-expanded.
- Read port: rd_key<=buf[rd_idx] at every edge, one-cycle latency. This works in every state, including during expansion, where entries not yet written return stale data. rd_idx > NUM_ROUNDS returns all zeros.
- The round counter is 4 bits and never wraps past NUM_ROUNDS.

Optional Feature:
KEYSCHED_CACHE_EN
- With macro: the block holds the key of the last completed schedule plus a cached flag.
  - A start with key_in equal to that key while keys_valid=1 skips EXPAND. The next state is FINISH directly, so done pulses in cycle N+1 and keys_valid stays 1.
  - The cached flag is cleared by rst and by an aborted expansion.
- Without macro: every start performs the full 10-round expansion. No comparator or key register is present.

Decomposition:
- Package aes_pkg holds:
  - typedef round_key_t = logic [vecSize-1:0][regSize-1:0]
  - AES_NUM_ROUNDS=10
  - state enum ks_state_e {IDLE, EXPAND, FINISH}
- One sub-module instance: key_expansion #(regSize, vecSize), the combinational round step. No other sub-modules.

Test Plan:
- Zero key: key_in all 0, start.
  - done exactly 11 cycles after start.
  - rd_idx=1 -> 62636363 62636363 62636363 62636363.
  - rd_idx=2 -> 9b9898c9 f9fbfbaa 9b9898c9 f9fbfbaa.
  - rd_idx=10 -> b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - rd_idx=0 returns the key.
  - rd_idx=1 -> a0fafe17 88542cb1 23a33939 2a6c7605.
  - rd_idx=10 -> d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- start pulsed at cycles 3 and 5 after the first start -> ignored; a single done at cycle 11; buffer matches the first key.
- rst asserted at EXPAND cycle 5 -> busy=0, keys_valid=0 next cycle. A new start completes normally with correct keys.
- rd_idx=11..15 -> rd_key=0. busy/done/keys_valid follow reset values after rst.
- KEYSCHED_CACHE_EN: repeat start with the FIPS key after completion.
  - done at cycle 1, keys_valid never drops.
  - A different key takes the full 11 cycles.
